// File: rtl/wbu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wbu_pkg : shared types and defaults for the wishbone-JTAG FIFO front  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package wbu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_OWN_A = 2'b01,
    ARB_OWN_B = 2'b10
  } arb_state_t;

  // Names the requester that won the most recent transfer
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

  localparam int C_DEFAULT_BW     = 36;
  localparam int C_DEFAULT_LGFLEN = 10;

endpackage
`default_nettype wire

// File: rtl/wbu_fifo_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wbu_fifo_arb_if : requester, FIFO-write and occupancy signals         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface wbu_fifo_arb_if
  import wbu_pkg::*;
#(
  parameter int BW     = C_DEFAULT_BW,
  parameter int LGFLEN = C_DEFAULT_LGFLEN
);
  logic              i_a_stb;
  logic [BW-1:0]     i_a_data;
  logic              i_a_last;
  logic              o_a_ready;
  logic              i_b_stb;
  logic [BW-1:0]     i_b_data;
  logic              i_b_last;
  logic              o_b_ready;
  logic              o_fifo_wr;
  logic [BW-1:0]     o_fifo_data;
  logic              i_fifo_rd;
  logic              i_fifo_empty_n;
  logic [LGFLEN:0]   o_fill;
  logic              o_full;
  logic              o_err;

  modport slave (
    input  i_a_stb, i_a_data, i_a_last, i_b_stb, i_b_data, i_b_last,
           i_fifo_rd, i_fifo_empty_n,
    output o_a_ready, o_b_ready, o_fifo_wr, o_fifo_data, o_fill, o_full, o_err
  );

  modport master (
    output i_a_stb, i_a_data, i_a_last, i_b_stb, i_b_data, i_b_last,
           i_fifo_rd, i_fifo_empty_n,
    input  o_a_ready, o_b_ready, o_fifo_wr, o_fifo_data, o_fill, o_full, o_err
  );
endinterface
`default_nettype wire

// File: rtl/wbu_fill_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wbu_fill_ctr : saturating FIFO occupancy counter (0..FLEN)            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module wbu_fill_ctr
  import wbu_pkg::*;
#(
  parameter int LGFLEN = C_DEFAULT_LGFLEN
) (
  input  wire logic              i_clk,
  input  wire logic              i_reset,
  input  wire logic              i_inc,
  input  wire logic              i_dec,
  output logic     [LGFLEN:0]    o_fill,
  output logic                   o_full
);
  localparam logic [LGFLEN:0] C_FLEN = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0] C_ONE  = {{LGFLEN{1'b0}}, 1'b1};

  logic [LGFLEN:0] r_fill;

  // Simultaneous inc and dec cancel; both directions guard against wrap
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_fill <= '0;
    else if (i_inc && !i_dec && (r_fill != C_FLEN))
      r_fill <= r_fill + C_ONE;
    else if (i_dec && !i_inc && (r_fill != '0))
      r_fill <= r_fill - C_ONE;
  end

  assign o_fill = r_fill;
  assign o_full = (r_fill == C_FLEN);
endmodule
`default_nettype wire

// File: rtl/wbu_fifo_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wbu_fifo_arb : round-robin two-requester writer for the codeword FIFO |
// | Optional packet lock: define WBUFIFO_ARB_LOCK_EN.   Rev 1.0           |
// +----------------------------------------------------------------------+
module wbu_fifo_arb
  import wbu_pkg::*;
#(
  parameter int BW     = C_DEFAULT_BW,
  parameter int LGFLEN = C_DEFAULT_LGFLEN
) (
  input  wire logic       i_clk,
  input  wire logic       i_reset,
  wbu_fifo_arb_if.slave   bus
);
  arb_state_t        r_state;
  arb_state_t        w_state_next;
  rr_t               r_rr;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_ready_a;
  logic              w_ready_b;
  logic              w_acc_a;
  logic              w_acc_b;
  logic              w_full;
  logic [LGFLEN:0]   w_fill;
  logic              r_fifo_wr;
  logic [BW-1:0]     r_fifo_data;
  logic              r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= ARB_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_grant_a    = bus.i_a_stb && (!bus.i_b_stb || (r_rr == RR_B));
    w_grant_b    = bus.i_b_stb && !w_grant_a;
    w_state_next = r_state;
`ifdef WBUFIFO_ARB_LOCK_EN
    // An owner keeps the grant even while its strobe is low
    case (r_state)
      ARB_OWN_A: begin
        w_grant_a = 1'b1;
        w_grant_b = 1'b0;
      end
      ARB_OWN_B: begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b1;
      end
      default: ;
    endcase
`endif
    w_ready_a = w_grant_a && !w_full;
    w_ready_b = w_grant_b && !w_full;
    w_acc_a   = bus.i_a_stb && w_ready_a;
    w_acc_b   = bus.i_b_stb && w_ready_b;
`ifdef WBUFIFO_ARB_LOCK_EN
    case (r_state)
      ARB_IDLE: begin
        if (w_acc_a && !bus.i_a_last)
          w_state_next = ARB_OWN_A;
        else if (w_acc_b && !bus.i_b_last)
          w_state_next = ARB_OWN_B;
      end
      ARB_OWN_A: if (w_acc_a && bus.i_a_last) w_state_next = ARB_IDLE;
      ARB_OWN_B: if (w_acc_b && bus.i_b_last) w_state_next = ARB_IDLE;
      default:   w_state_next = ARB_IDLE;
    endcase
`else
    w_state_next = ARB_IDLE;
`endif
  end

`ifndef WBUFIFO_ARB_LOCK_EN
  logic w_unused;
  assign w_unused = ^{bus.i_a_last, bus.i_b_last, r_state};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_rr <= RR_B;
    else if (w_acc_a)
      r_rr <= RR_A;
    else if (w_acc_b)
      r_rr <= RR_B;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
    end else begin
      r_fifo_wr <= w_acc_a || w_acc_b;
      if (w_acc_a)
        r_fifo_data <= bus.i_a_data;
      else if (w_acc_b)
        r_fifo_data <= bus.i_b_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_err <= 1'b0;
    else if (bus.i_fifo_rd && !bus.i_fifo_empty_n)
      r_err <= 1'b1;
  end

  // Counting at accept time covers the word still in the output register
  wbu_fill_ctr #(
    .LGFLEN (LGFLEN)
  ) u_fill_ctr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_acc_a || w_acc_b),
    .i_dec   (bus.i_fifo_rd && bus.i_fifo_empty_n),
    .o_fill  (w_fill),
    .o_full  (w_full)
  );

  assign bus.o_a_ready   = w_ready_a;
  assign bus.o_b_ready   = w_ready_b;
  assign bus.o_fifo_wr   = r_fifo_wr;
  assign bus.o_fifo_data = r_fifo_data;
  assign bus.o_fill      = w_fill;
  assign bus.o_full      = w_full;
  assign bus.o_err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_wbu_fifo_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wbu_fifo_arb : directed stimulus with a FIFO-write scoreboard      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_wbu_fifo_arb;
  localparam int BW     = 36;
  localparam int LGFLEN = 2;

  localparam logic [BW-1:0] A0 = 36'h0_AAAA_0001, A1 = 36'h0_AAAA_0002;
  localparam logic [BW-1:0] A2 = 36'h0_AAAA_0003, A3 = 36'h0_AAAA_0004;
  localparam logic [BW-1:0] B0 = 36'h0_BBBB_0001, B1 = 36'h0_BBBB_0002;
  localparam logic [BW-1:0] W0 = 36'h0_CCCC_0000, W1 = 36'h0_CCCC_0001;
  localparam logic [BW-1:0] W2 = 36'h0_CCCC_0002, W3 = 36'h0_CCCC_0003;
  localparam logic [BW-1:0] W4 = 36'h0_CCCC_0004, W5 = 36'h0_CCCC_0005;
  localparam logic [BW-1:0] W6 = 36'h0_CCCC_0006;
  localparam logic [BW-1:0] R0 = 36'h0_DDDD_0000, R1 = 36'h0_DDDD_0001;
  localparam logic [BW-1:0] R2 = 36'h0_DDDD_0002, R3 = 36'h0_DDDD_0003;
  localparam logic [BW-1:0] R4 = 36'h0_DDDD_0004;
  localparam logic [BW-1:0] Z  = '0;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  wbu_fifo_arb_if #(.BW(BW), .LGFLEN(LGFLEN)) bus();

  wbu_fifo_arb #(.BW(BW), .LGFLEN(LGFLEN)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected word
  always @(posedge i_clk) begin
    #1;
    if (bus.o_fifo_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_wr_unexpected: got data 0x%0h, expected no write", bus.o_fifo_data);
      end else begin
        check("fifo_data", bus.o_fifo_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic as, input logic [BW-1:0] ad, input logic al,
                     input logic bs, input logic [BW-1:0] bd, input logic bl,
                     input logic rd, input logic en,
                     input logic ear, input logic ebr, input string nm);
    bus.i_a_stb        = as;
    bus.i_a_data       = ad;
    bus.i_a_last       = al;
    bus.i_b_stb        = bs;
    bus.i_b_data       = bd;
    bus.i_b_last       = bl;
    bus.i_fifo_rd      = rd;
    bus.i_fifo_empty_n = en;
    #1;
    check({nm, ".a_ready"}, bus.o_a_ready, ear);
    check({nm, ".b_ready"}, bus.o_b_ready, ebr);
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    bus.i_a_stb = 1'b0; bus.i_a_data = Z; bus.i_a_last = 1'b0;
    bus.i_b_stb = 1'b0; bus.i_b_data = Z; bus.i_b_last = 1'b0;
    bus.i_fifo_rd = 1'b0; bus.i_fifo_empty_n = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    idle_inputs();
    @(negedge i_clk);
    do_reset();

    check("rst.fifo_wr", bus.o_fifo_wr, 0);
    check("rst.fifo_data", bus.o_fifo_data, 0);
    check("rst.fill", bus.o_fill, 0);
    check("rst.full", bus.o_full, 0);
    check("rst.err", bus.o_err, 0);

    // Single word from A: ready now, written one cycle later
    exp_q.push_back(36'h1_2345_6789);
    cyc(1, 36'h1_2345_6789, 0, 0, Z, 0, 0, 0, 1, 0, "t1_c0");
    check("t1.fifo_wr", bus.o_fifo_wr, 1);
    check("t1.fifo_data", bus.o_fifo_data, 36'h1_2345_6789);
    check("t1.fill", bus.o_fill, 1);
    cyc(0, Z, 0, 0, Z, 0, 0, 0, 0, 0, "t1_c1");
    check("t1.fifo_wr_pulse", bus.o_fifo_wr, 0);

    // Both requesters held valid: alternating grants starting with A
    do_reset();
    exp_q.push_back(A0); exp_q.push_back(B0); exp_q.push_back(A1); exp_q.push_back(B1);
    cyc(1, A0, 0, 1, B0, 0, 0, 0, 1, 0, "t2_c0");
    cyc(1, A1, 0, 1, B0, 0, 0, 0, 0, 1, "t2_c1");
    cyc(1, A1, 0, 1, B1, 0, 0, 0, 1, 0, "t2_c2");
    cyc(1, A2, 0, 1, B1, 0, 0, 0, 0, 1, "t2_c3");
    check("t2.fill", bus.o_fill, 4);
    check("t2.full", bus.o_full, 1);
    cyc(0, Z, 0, 0, Z, 0, 0, 0, 0, 0, "t2_c4");

    // Fill to FLEN=4, stall, reopen one cycle after a read
    do_reset();
    exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
    exp_q.push_back(W4); exp_q.push_back(W5); exp_q.push_back(W6);
    cyc(1, W0, 0, 0, Z, 0, 0, 0, 1, 0, "t3_c0");
    cyc(1, W1, 0, 0, Z, 0, 0, 0, 1, 0, "t3_c1");
    cyc(1, W2, 0, 0, Z, 0, 0, 0, 1, 0, "t3_c2");
    cyc(1, W3, 0, 0, Z, 0, 0, 0, 1, 0, "t3_c3");
    check("t3.full_at_4", bus.o_full, 1);
    check("t3.fill_at_4", bus.o_fill, 4);
    cyc(1, W4, 0, 0, Z, 0, 1, 1, 0, 0, "t3_c4_full_read");
    check("t3.fill_after_read", bus.o_fill, 3);
    check("t3.full_after_read", bus.o_full, 0);
    cyc(1, W4, 0, 0, Z, 0, 0, 0, 1, 0, "t3_c5_reopen");
    cyc(1, W5, 0, 0, Z, 0, 0, 0, 0, 0, "t3_c6");
    cyc(1, W5, 0, 0, Z, 0, 1, 1, 0, 0, "t3_c7");
    cyc(1, W5, 0, 0, Z, 0, 0, 0, 1, 0, "t3_c8");
    check("t3.fill_refull", bus.o_fill, 4);
    cyc(0, Z, 0, 0, Z, 0, 1, 1, 0, 0, "t3_c9");
    cyc(0, Z, 0, 0, Z, 0, 1, 1, 0, 0, "t3_c10");
    check("t3.fill_drain", bus.o_fill, 2);

    // Accept and read together; then read while empty
    cyc(1, W6, 0, 0, Z, 0, 1, 1, 1, 0, "t4_c0");
    check("t4.fill_inc_dec", bus.o_fill, 2);
    cyc(0, Z, 0, 0, Z, 0, 1, 0, 0, 0, "t4_c1");
    check("t4.err", bus.o_err, 1);
    check("t4.fill_on_err", bus.o_fill, 2);
    cyc(0, Z, 0, 0, Z, 0, 0, 0, 0, 0, "t4_c2");
    check("t4.err_sticky", bus.o_err, 1);

`ifdef WBUFIFO_ARB_LOCK_EN
    // A owns the port for a 3-word packet; B waits, then wins the tie
    do_reset();
    exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A2);
    exp_q.push_back(B0); exp_q.push_back(A3);
    cyc(1, A0, 0, 1, B0, 1, 0, 0, 1, 0, "t5_c0");
    cyc(1, A1, 0, 1, B0, 1, 1, 1, 1, 0, "t5_c1");
    cyc(1, A2, 1, 1, B0, 1, 1, 1, 1, 0, "t5_c2");
    cyc(1, A3, 1, 1, B0, 1, 1, 1, 0, 1, "t5_c3");
    cyc(1, A3, 1, 0, Z, 0, 1, 1, 1, 0, "t5_c4");
    cyc(0, Z, 0, 0, Z, 0, 0, 0, 0, 0, "t5_c5");
    check("t5.fill", bus.o_fill, 1);
`endif

    // Reset while a write is pending
    do_reset();
    cyc(0, Z, 0, 0, Z, 0, 1, 0, 0, 0, "t6_err");
    check("t6.err_set", bus.o_err, 1);
    exp_q.push_back(R0); exp_q.push_back(R1); exp_q.push_back(R2);
    cyc(1, R0, 0, 0, Z, 0, 0, 0, 1, 0, "t6_c0");
    cyc(1, R1, 0, 0, Z, 0, 0, 0, 1, 0, "t6_c1");
    cyc(1, R2, 0, 0, Z, 0, 0, 0, 1, 0, "t6_c2");
    check("t6.fifo_wr_pending", bus.o_fifo_wr, 1);
    check("t6.fill_pending", bus.o_fill, 3);
    i_reset = 1'b1;
    idle_inputs();
    @(negedge i_clk);
    i_reset = 1'b0;
    check("t6.fifo_wr_dropped", bus.o_fifo_wr, 0);
    check("t6.fill_cleared", bus.o_fill, 0);
    check("t6.err_cleared", bus.o_err, 0);
    exp_q.push_back(R3);
    cyc(1, R3, 0, 1, R4, 0, 0, 0, 1, 0, "t6_tie");
    cyc(0, Z, 0, 0, Z, 0, 0, 0, 0, 0, "t6_c3");
    cyc(0, Z, 0, 0, Z, 0, 0, 0, 0, 0, "t6_c4");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
